// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache, one word per line
// Ports:
//   CLK, nRST          clock, synchronous active-low reset
//   imemREN/imemaddr   fetch request and byte address from the pipeline
//   imemload/ihit      fetched word and same-cycle hit indication
//   flush              invalidate every line at the next edge
//   iREN/iaddr         word read request to the memory controller
//   iwait/iload        memory busy flag and returned read data
//   hit_count/miss_count  statistics counters, present only with ICACHE_STATS_EN
module icache_direct #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        ihit,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int TAG_W = 30 - IDX_W;
  typedef enum logic {IDLE, FILL} state_t;
  state_t            state_q, state_d;
  logic [31:0]       fill_addr_q, fill_addr_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q [SETS];
  logic [31:0]       data_q [SETS];
  logic [IDX_W-1:0]  idx, fill_idx;
  logic [TAG_W-1:0]  tag, fill_tag;
  logic              hit, start, fill_done;
  logic              unused_ok;
  assign unused_ok = ^imemaddr[1:0];
  assign idx       = imemaddr[IDX_W+1:2];
  assign tag       = imemaddr[31:IDX_W+2];
  assign fill_idx  = fill_addr_q[IDX_W+1:2];
  assign fill_tag  = fill_addr_q[31:IDX_W+2];
  assign hit       = state_q == IDLE && imemREN && valid_q[idx] && tag_q[idx] == tag;
  assign start     = state_q == IDLE && imemREN && !hit && !flush;
  assign fill_done = state_q == FILL && !iwait;
  assign ihit      = hit;
  assign imemload  = hit ? data_q[idx] : '0;
  assign iREN      = state_q == FILL;
  assign iaddr     = fill_addr_q;
  always_comb begin
    state_d     = start ? FILL : fill_done ? IDLE : state_q;
    fill_addr_d = start ? {imemaddr[31:2], 2'b00} : fill_addr_q;
    // flush overrides a completing fill so the just-filled line stays invalid
    valid_d     = flush ? '0 : fill_done ? valid_q | (SETS'(1) << fill_idx) : valid_q;
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      fill_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      valid_q     <= valid_d;
    end
  end
  // tag/data need no reset: they are only observed through a valid bit
  always_ff @(posedge CLK) begin
    if (nRST && fill_done) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      hit_count  <= hit_count + 32'(hit);
      miss_count <= miss_count + 32'(start);
    end
  end
`endif
endmodule
